// File: rtl/gps_pkg.sv
// Shared definitions for the NMEA sentence filter: framing characters,
// the framer state encoding and an ASCII hex digit decoder.
package gps_pkg;

  // Framing characters of an NMEA sentence: $ ... *hh CR LF
  localparam logic [7:0] CH_DOLLAR = 8'h24;
  localparam logic [7:0] CH_STAR   = 8'h2A;
  localparam logic [7:0] CH_CR     = 8'h0D;
  localparam logic [7:0] CH_LF     = 8'h0A;

  // Framer states. Encoding is fixed so the debug port has stable values.
  typedef enum logic [2:0] {
    HUNT  = 3'd0,
    BODY  = 3'd1,
    CS_HI = 3'd2,
    CS_LO = 3'd3,
    CR    = 3'd4,
    LF    = 3'd5,
    EMIT  = 3'd6
  } nmea_st_t;

  // Decode one ASCII hex digit. Only 0-9 and uppercase A-F are legal in an
  // NMEA checksum field. Result is {valid, nibble}; nibble is 0 when invalid.
  function automatic logic [4:0] hex_to_nibble(input logic [7:0] ch);
    logic [4:0] res;
    res = 5'b0_0000;
    if (ch >= 8'h30 && ch <= 8'h39) begin
      res = {1'b1, ch[3:0]};
    end else if (ch >= 8'h41 && ch <= 8'h46) begin
      // 'A' is 0x41, so the low nibble plus 9 gives 10..15
      res = {1'b1, ch[3:0] + 4'd9};
    end
    return res;
  endfunction

endpackage

// File: rtl/nmea_line_ram.sv
// Sentence line buffer: one synchronous write port used while a sentence is
// being framed, one asynchronous read port used while it is being emitted.
module nmea_line_ram
  import gps_pkg::*;
#(
  parameter int MAX_LEN = 82,
  parameter int IW      = $clog2(MAX_LEN + 1)
) (
  input  logic          clk,
  input  logic          we_i,
  input  logic [IW-1:0] wr_idx_i,
  input  logic [7:0]    wr_data_i,
  input  logic [IW-1:0] rd_idx_i,
  output logic [7:0]    rd_data_o
);

  localparam logic [IW-1:0] DEPTH = IW'(MAX_LEN);

  logic [7:0] mem [MAX_LEN];

  // Store the accepted byte; the index guard keeps writes inside the array
  // for every MAX_LEN, including powers of two where IW has a spare bit.
  always_ff @(posedge clk) begin
    if (we_i && (wr_idx_i < DEPTH)) begin
      mem[wr_idx_i] <= wr_data_i;
    end
  end

  // Combinational read so out_data follows rd_idx in the same cycle.
  assign rd_data_o = (rd_idx_i < DEPTH) ? mem[rd_idx_i] : 8'h00;

endmodule

// File: rtl/nmea_sentence_filter.sv
// NMEA sentence filter: frames "$...*hh\r\n" sentences from a raw byte
// stream, checks the XOR checksum and forwards only valid sentences.
//
// Handshakes: the input side has no back-pressure beyond in_ready; a byte is
// taken when in_valid & in_ready, and in_valid while in_ready is low is lost
// and reported by drop. The output side is strict valid/ready: once out_valid
// rises, out_data/out_last hold until out_valid & out_ready, and out_valid
// never drops without a handshake (except on reset).
module nmea_sentence_filter
  import gps_pkg::*;
#(
  parameter int MAX_LEN = 82
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  input  logic [7:0]  in_data,
  output logic        in_ready,
  output logic        out_valid,
  output logic [7:0]  out_data,
  output logic        out_last,
  input  logic        out_ready,
  output logic        crc_err,
  output logic        fmt_err,
  output logic        ovf_err,
  output logic        drop,
  output logic [15:0] sent_cnt,
  output logic [2:0]  dbg_state
);

  localparam int              IW      = $clog2(MAX_LEN + 1);
  localparam logic [IW-1:0]   LEN_MAX = IW'(MAX_LEN);
  localparam logic [IW-1:0]   IDX_ONE = IW'(1);

  // Registered state and next-state values
  nmea_st_t      state_q, state_d;
  logic [IW-1:0] len_q, len_d;
  logic [IW-1:0] rd_idx_q, rd_idx_d;
  logic [7:0]    xor_q, xor_d;
  logic [3:0]    hi_q, hi_d;
  logic [3:0]    lo_q, lo_d;
  logic [15:0]   cnt_q, cnt_d;
  logic          crc_q, crc_d;
  logic          fmt_q, fmt_d;
  logic          ovf_q, ovf_d;
  logic          drop_q, drop_d;

  // Line buffer write controls and read data
  logic          ram_we;
  logic [IW-1:0] ram_wr_idx;
  logic [7:0]    ram_rd_data;

  logic          accept;
  logic          emit_last;
  logic          out_hs;
  logic [4:0]    hex;

  assign hex       = hex_to_nibble(in_data);
  assign in_ready  = (state_q != EMIT);
  assign accept    = in_valid & in_ready;
  assign out_valid = (state_q == EMIT);
  assign emit_last = (rd_idx_q == (len_q - IDX_ONE));
  assign out_hs    = out_valid & out_ready;

  // Output byte and last flag are forced to zero outside EMIT so that idle
  // and reset values do not expose stale buffer contents.
  assign out_data  = out_valid ? ram_rd_data : 8'h00;
  assign out_last  = out_valid & emit_last;

  assign crc_err   = crc_q;
  assign fmt_err   = fmt_q;
  assign ovf_err   = ovf_q;
  assign drop      = drop_q;
  assign sent_cnt  = cnt_q;
  assign dbg_state = state_q;

  nmea_line_ram #(
    .MAX_LEN (MAX_LEN),
    .IW      (IW)
  ) u_line_ram (
    .clk       (clk),
    .we_i      (ram_we),
    .wr_idx_i  (ram_wr_idx),
    .wr_data_i (in_data),
    .rd_idx_i  (rd_idx_q),
    .rd_data_o (ram_rd_data)
  );

  // Framer / emitter next-state logic
  always_comb begin
    state_d    = state_q;
    len_d      = len_q;
    rd_idx_d   = rd_idx_q;
    xor_d      = xor_q;
    hi_d       = hi_q;
    lo_d       = lo_q;
    cnt_d      = cnt_q;
    crc_d      = 1'b0;
    fmt_d      = 1'b0;
    ovf_d      = 1'b0;
    // Only EMIT lowers in_ready, so drop can never coincide with an error.
    drop_d     = in_valid & ~in_ready;
    ram_we     = 1'b0;
    ram_wr_idx = len_q;

    if (state_q == EMIT) begin
      if (out_hs) begin
        if (emit_last) begin
          cnt_d    = cnt_q + 16'd1;
          len_d    = '0;
          rd_idx_d = '0;
          state_d  = HUNT;
        end else begin
          rd_idx_d = rd_idx_q + IDX_ONE;
        end
      end
    end else if (accept) begin
      if (state_q == HUNT) begin
        // Everything before a '$' is line noise and is skipped silently.
        if (in_data == CH_DOLLAR) begin
          ram_we     = 1'b1;
          ram_wr_idx = '0;
          len_d      = IDX_ONE;
          xor_d      = 8'h00;
          state_d    = BODY;
        end
      end else if (len_q == LEN_MAX) begin
        // Buffer full: the byte is dropped whatever it is, even a '$'.
        ovf_d   = 1'b1;
        len_d   = '0;
        state_d = HUNT;
      end else begin
        case (state_q)
          BODY: begin
            ram_we = 1'b1;
            if (in_data == CH_DOLLAR) begin
              // A new '$' abandons the fragment and starts over at index 0.
              ram_wr_idx = '0;
              len_d      = IDX_ONE;
              xor_d      = 8'h00;
            end else begin
              len_d = len_q + IDX_ONE;
              if (in_data == CH_STAR) begin
                state_d = CS_HI;
              end else begin
                xor_d = xor_q ^ in_data;
              end
            end
          end
          CS_HI: begin
            if (hex[4]) begin
              ram_we  = 1'b1;
              len_d   = len_q + IDX_ONE;
              hi_d    = hex[3:0];
              state_d = CS_LO;
            end else begin
              fmt_d   = 1'b1;
              len_d   = '0;
              state_d = HUNT;
            end
          end
          CS_LO: begin
            if (hex[4]) begin
              ram_we  = 1'b1;
              len_d   = len_q + IDX_ONE;
              lo_d    = hex[3:0];
              state_d = CR;
            end else begin
              fmt_d   = 1'b1;
              len_d   = '0;
              state_d = HUNT;
            end
          end
          CR: begin
            if (in_data == CH_CR) begin
              ram_we  = 1'b1;
              len_d   = len_q + IDX_ONE;
              state_d = LF;
            end else begin
              fmt_d   = 1'b1;
              len_d   = '0;
              state_d = HUNT;
            end
          end
          LF: begin
            if (in_data != CH_LF) begin
              fmt_d   = 1'b1;
              len_d   = '0;
              state_d = HUNT;
            end else if ({hi_q, lo_q} == xor_q) begin
              // Sentence complete and intact: len now counts the LF too.
              ram_we   = 1'b1;
              len_d    = len_q + IDX_ONE;
              rd_idx_d = '0;
              state_d  = EMIT;
            end else begin
              crc_d   = 1'b1;
              len_d   = '0;
              state_d = HUNT;
            end
          end
          default: begin
            len_d   = '0;
            state_d = HUNT;
          end
        endcase
      end
    end
  end

  // State, accumulators, counter and registered pulses
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= HUNT;
      len_q    <= '0;
      rd_idx_q <= '0;
      xor_q    <= 8'h00;
      hi_q     <= 4'h0;
      lo_q     <= 4'h0;
      cnt_q    <= 16'd0;
      crc_q    <= 1'b0;
      fmt_q    <= 1'b0;
      ovf_q    <= 1'b0;
      drop_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      len_q    <= len_d;
      rd_idx_q <= rd_idx_d;
      xor_q    <= xor_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      cnt_q    <= cnt_d;
      crc_q    <= crc_d;
      fmt_q    <= fmt_d;
      ovf_q    <= ovf_d;
      drop_q   <= drop_d;
    end
  end

endmodule

// File: tb/tb_nmea_sentence_filter.sv
// Self-checking bench for nmea_sentence_filter: directed sentences from the
// test plan followed by randomized sentences, all checked against a
// queue-based sentence parser kept in the bench.
module tb_nmea_sentence_filter;

  localparam int MAX_LEN = 82;

  // ---------------- clock / reset / DUT ----------------
  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic [7:0]  in_data;
  logic        in_ready;
  logic        out_valid;
  logic [7:0]  out_data;
  logic        out_last;
  logic        out_ready;
  logic        crc_err;
  logic        fmt_err;
  logic        ovf_err;
  logic        drop;
  logic [15:0] sent_cnt;
  logic [2:0]  dbg_state;

  always #5 clk = ~clk;

  nmea_sentence_filter #(.MAX_LEN(MAX_LEN)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_last  (out_last),
    .out_ready (out_ready),
    .crc_err   (crc_err),
    .fmt_err   (fmt_err),
    .ovf_err   (ovf_err),
    .drop      (drop),
    .sent_cnt  (sent_cnt),
    .dbg_state (dbg_state)
  );

  // ---------------- bookkeeping ----------------
  int chk_cnt = 0;
  int err_cnt = 0;

  logic [8:0] exp_q[$];          // {last, data} of every byte that must come out
  logic [7:0] cur[$];            // model: sentence being collected
  int         star_pos = -1;     // model: index of '*' in cur, -1 if not seen
  int exp_crc = 0, exp_fmt = 0, exp_ovf = 0, exp_drop = 0, exp_sent = 0, exp_bytes = 0;
  int obs_crc = 0, obs_fmt = 0, obs_ovf = 0, obs_drop = 0, obs_bytes = 0;

  logic       rand_ready   = 1'b0;
  logic       toggle_ready = 1'b0;
  logic       hold_prev    = 1'b0;
  logic [8:0] prev_out     = '0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    chk_cnt++;
    assert (obs === exp) else begin
      err_cnt++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic int hex_val(input logic [7:0] c);
    if (c >= "0" && c <= "9") return int'(c) - int'("0");
    if (c >= "A" && c <= "F") return int'(c) - int'("A") + 10;
    return -1;
  endfunction

  function automatic logic [7:0] hex_chr(input int n);
    if (n < 10) return 8'(int'("0") + n);
    return 8'(int'("A") + n - 10);
  endfunction

  task automatic model_clear();
    cur.delete();
    star_pos = -1;
  endtask

  // Feed one accepted byte to the sentence parser.
  task automatic model_byte(input logic [7:0] b);
    int k;
    int want;
    logic [7:0] x;
    if (cur.size() == 0) begin
      if (b == "$") cur.push_back(b);
      return;
    end
    if (cur.size() == MAX_LEN) begin
      exp_ovf++;
      model_clear();
      return;
    end
    if (star_pos < 0) begin
      if (b == "$") begin
        model_clear();
        cur.push_back(b);
      end else begin
        cur.push_back(b);
        if (b == "*") star_pos = cur.size() - 1;
      end
      return;
    end
    k = cur.size() - star_pos;   // 1,2: hex digits, 3: CR, 4: LF
    if ((k <= 2 && hex_val(b) < 0) || (k == 3 && b != 8'h0D) || (k == 4 && b != 8'h0A)) begin
      exp_fmt++;
      model_clear();
      return;
    end
    cur.push_back(b);
    if (k == 4) begin
      x = 8'h00;
      for (int i = 1; i < star_pos; i++) x = x ^ cur[i];
      want = hex_val(cur[star_pos+1]) * 16 + hex_val(cur[star_pos+2]);
      if (int'(x) == want) begin
        for (int i = 0; i < cur.size(); i++) begin
          exp_q.push_back({(i == cur.size() - 1), cur[i]});
          exp_bytes++;
        end
        exp_sent++;
      end else begin
        exp_crc++;
      end
      model_clear();
    end
  endtask

  // ---------------- driver tasks (start and end at posedge+1) ----------------
  task automatic send_byte(input logic [7:0] b);
    int g;
    g = 0;
    while (!in_ready && g < 2000) begin
      @(posedge clk); #1;
      g++;
    end
    if (g >= 2000) check("in_ready_timeout", 32'(in_ready), 32'd1);
    in_valid = 1'b1;
    in_data  = b;
    @(posedge clk); #1;
    in_valid = 1'b0;
    model_byte(b);
  endtask

  task automatic send_str(input string s);
    for (int i = 0; i < s.len(); i++) send_byte(s[i]);
  endtask

  task automatic send_crlf();
    send_byte(8'h0D);
    send_byte(8'h0A);
  endtask

  task automatic wait_idle();
    int g;
    g = 0;
    while ((exp_q.size() != 0 || !in_ready) && g < 3000) begin
      @(posedge clk); #1;
      g++;
    end
    check("idle_wait", 32'(g < 3000), 32'd1);
    repeat (2) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic check_counts(input string tag);
    check({tag, "_sent_cnt"}, 32'(sent_cnt), 32'(exp_sent[15:0]));
    check({tag, "_crc"},      32'(obs_crc),   32'(exp_crc));
    check({tag, "_fmt"},      32'(obs_fmt),   32'(exp_fmt));
    check({tag, "_ovf"},      32'(obs_ovf),   32'(exp_ovf));
    check({tag, "_drop"},     32'(obs_drop),  32'(exp_drop));
    check({tag, "_bytes"},    32'(obs_bytes), 32'(exp_bytes));
  endtask

  // out_ready pattern generator, acting at posedge+2
  always @(posedge clk) begin
    #2;
    if (rand_ready) out_ready = 1'($urandom_range(0, 1));
    else if (toggle_ready) out_ready = ~out_ready;
  end

  // ---------------- scoreboard / monitor ----------------
  always @(negedge clk) begin
    if (rst) begin
      if (crc_err) obs_crc++;
      if (fmt_err) obs_fmt++;
      if (ovf_err) obs_ovf++;
      if (drop)    obs_drop++;
      if (crc_err | fmt_err | ovf_err | drop)
        check("pulse_exclusive",
              32'(crc_err) + 32'(fmt_err) + 32'(ovf_err) + 32'(drop), 32'd1);
      if (out_valid) begin
        check("in_ready_low_in_emit", 32'(in_ready), 32'd0);
        if (hold_prev) check("out_hold_stable", 32'({out_last, out_data}), 32'(prev_out));
      end
      if (out_valid && out_ready) begin
        chk_cnt++;
        assert (exp_q.size() != 0) else begin
          err_cnt++;
          $error("FAIL out_unexpected: observed %0h expected none", {out_last, out_data});
        end
        if (exp_q.size() != 0) begin
          check("out_byte", 32'({out_last, out_data}), 32'(exp_q.pop_front()));
          obs_bytes++;
        end
      end
      hold_prev = out_valid && !out_ready;
      prev_out  = {out_last, out_data};
    end else begin
      hold_prev = 1'b0;
    end
  end

  // Absolute time bound
  initial begin
    #900_000;
    $display("FAIL global_timeout: observed running expected finished");
    $fatal(1, "timeout");
  end

  // ---------------- directed + random stimulus ----------------
  initial begin
    logic [7:0] body[$];
    logic [7:0] x;
    logic [7:0] cs;
    int         blen;
    int         kind;

    rst       = 1'b0;
    in_valid  = 1'b0;
    in_data   = 8'h00;
    out_ready = 1'b1;
    model_clear();
    repeat (3) @(posedge clk);
    #1;

    // Reset state
    check("rst_in_ready",  32'(in_ready),  32'd1);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_data",  32'(out_data),  32'd0);
    check("rst_out_last",  32'(out_last),  32'd0);
    check("rst_sent_cnt",  32'(sent_cnt),  32'd0);
    check("rst_state",     32'(dbg_state), 32'd0);
    rst = 1'b1;
    @(posedge clk); #1;

    // Basic sentence; out_valid must be up right after LF is accepted
    send_str("$A*41");
    send_crlf();
    check("t1_out_valid_after_lf", 32'(out_valid), 32'd1);
    wait_idle();
    check_counts("t1");

    // Good then bad checksum
    send_str("$AB*03");
    send_crlf();
    send_str("$A*40");
    send_crlf();
    wait_idle();
    check_counts("t2");

    // Leading garbage and restarted fragment
    send_str("xx$X$A*41");
    send_crlf();
    wait_idle();
    check_counts("t3");

    // Lowercase hex digit, then missing CR
    send_str("$A*4g");
    send_crlf();
    send_str("$A*41");
    send_byte(8'h0A);
    wait_idle();
    check_counts("t4");

    // Overflow at the 83rd byte, then recovery
    send_byte("$");
    for (int i = 0; i < 82; i++) send_byte("A");
    send_str("$A*41");
    send_crlf();
    wait_idle();
    check_counts("t5");

    // Toggling out_ready during EMIT with three lost input bytes
    out_ready = 1'b0;
    send_str("$A*41");
    send_crlf();
    check("t6_in_emit", 32'(out_valid), 32'd1);
    toggle_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1;
      in_data  = 8'($urandom_range(0, 255));
      @(posedge clk); #1;
      check("t6_in_ready_low", 32'(in_ready), 32'd0);
    end
    in_valid = 1'b0;
    exp_drop += 3;
    toggle_ready = 1'b0;
    out_ready    = 1'b1;
    wait_idle();
    check_counts("t6");

    // Randomized sentences with random back-pressure and corruption
    rand_ready = 1'b1;
    for (int n = 0; n < 40; n++) begin
      body.delete();
      for (int g = 0; g < int'($urandom_range(0, 3)); g++)
        send_byte(8'($urandom_range(int'("a"), int'("z"))));
      blen = ($urandom_range(0, 19) == 0) ? 85 : int'($urandom_range(0, 12));
      x = 8'h00;
      for (int i = 0; i < blen; i++) begin
        logic [7:0] c;
        c = 8'($urandom_range(8'h20, 8'h7E));
        if (c == "$" || c == "*") c = "G";
        body.push_back(c);
        x = x ^ c;
      end
      kind = int'($urandom_range(0, 9));
      cs = (kind == 0) ? (x ^ 8'(1 << $urandom_range(0, 7))) : x;
      send_byte("$");
      foreach (body[i]) send_byte(body[i]);
      send_byte("*");
      send_byte(hex_chr(int'(cs[7:4])));
      send_byte((kind == 1) ? 8'("a") : hex_chr(int'(cs[3:0])));
      if (kind != 2) send_byte(8'h0D);
      send_byte(8'h0A);
    end
    rand_ready = 1'b0;
    #1;
    out_ready = 1'b1;
    wait_idle();
    check_counts("rand");

    // Reset in the middle of EMIT
    out_ready = 1'b0;
    send_str("$A*41");
    send_crlf();
    check("t7_in_emit", 32'(out_valid), 32'd1);
    #3;
    rst = 1'b0;
    #1;
    check("t7_rst_out_valid", 32'(out_valid), 32'd0);
    check("t7_rst_out_data",  32'(out_data),  32'd0);
    check("t7_rst_out_last",  32'(out_last),  32'd0);
    check("t7_rst_in_ready",  32'(in_ready),  32'd1);
    check("t7_rst_sent_cnt",  32'(sent_cnt),  32'd0);
    check("t7_rst_pulses",    32'({crc_err, fmt_err, ovf_err, drop}), 32'd0);
    check("t7_rst_state",     32'(dbg_state), 32'd0);
    exp_q.delete();
    model_clear();
    exp_crc = 0; exp_fmt = 0; exp_ovf = 0; exp_drop = 0; exp_sent = 0; exp_bytes = 0;
    obs_crc = 0; obs_fmt = 0; obs_ovf = 0; obs_drop = 0; obs_bytes = 0;
    @(posedge clk); #1;
    rst = 1'b1;
    out_ready = 1'b1;
    repeat (3) begin
      @(posedge clk); #1;
    end
    check("t7_no_tail", 32'(out_valid), 32'd0);
    check("t7_hunt",    32'(dbg_state), 32'd0);
    send_str("$AB*03");
    send_crlf();
    wait_idle();
    check_counts("t7");

    $display("Simulation finished: %0d checks, %0d errors", chk_cnt, err_cnt);
    $finish;
  end

endmodule

// File: doc/nmea_sentence_filter.md
# nmea_sentence_filter

Downstream consumer of the GPS-side AXI-Lite polling master: receives the raw byte stream read from the GPS UART RX FIFO, frames NMEA sentences (`$` … `*hh\r\n`), verifies the XOR checksum and forwards only valid, complete sentences as a byte stream with valid/ready handshaking. Its output feeds the FTDI-side transmit path. Malformed, overlong or corrupted sentences are discarded and flagged.

## Interface
Parameters:
- `MAX_LEN`, default 82: maximum stored sentence length in bytes, including `$`, `*hh` and CRLF.

Ports:
- `clk`  in  1  system clock.
- `rst`  in  1  asynchronous, active-low reset.
- `in_valid`  in  1  input byte strobe, one cycle per byte.
- `in_data`  in  8  input byte.
- `in_ready`  out  1  high when the block accepts input bytes.
- `out_valid`  out  1  output byte valid.
- `out_data`  out  8  output byte.
- `out_last`  out  1  high with the final byte (`\n`) of a sentence.
- `out_ready`  in  1  downstream accepts the byte.
- `crc_err`  out  1  one-cycle pulse: checksum mismatch.
- `fmt_err`  out  1  one-cycle pulse: bad hex digit or missing CR/LF.
- `ovf_err`  out  1  one-cycle pulse: sentence exceeded `MAX_LEN`.
- `drop`  out  1  one-cycle pulse: `in_valid` while `in_ready`=0.
- `sent_cnt`  out  16  count of forwarded sentences, wraps mod 2^16.

## Operation
- Reset: state HUNT; `in_ready`=1; `out_valid`, `out_last`, `out_data`, all error pulses and `drop`=0; `sent_cnt`=0; length and XOR accumulators cleared.
- A byte is accepted when `in_valid & in_ready`. Every accepted byte in states other than HUNT is stored at index `len`, and `len` is incremented.
- HUNT: `$` (0x24) stores at index 0, sets `len`=1 and `xor`=0, and moves to BODY. All other bytes are discarded silently.
- BODY:
  - `$` restarts the sentence: `len`=1, `xor`=0, state stays BODY.
  - `*` (0x2A) is stored, then the state moves to CS_HI.
  - Any other byte is stored and `xor ^= byte`.
- CS_HI, CS_LO: the accepted characters are ASCII `0`–`9` and `A`–`F` (uppercase only). Each digit is stored and its nibble latched. Any other character pulses `fmt_err` and returns to HUNT.
- CR: the byte must be 0x0D. Anything else pulses `fmt_err` and returns to HUNT.
- LF: the byte must be 0x0A. Anything else pulses `fmt_err` and returns to HUNT.
  - On LF, if `{hi,lo} == xor`, the state moves to EMIT.
  - Otherwise `crc_err` pulses and the state returns to HUNT.
- Overflow: accepting a byte while `len == MAX_LEN` (outside HUNT) pulses `ovf_err` and returns to HUNT. That byte is discarded, even if it is `$`.
- EMIT:
  - `in_ready`=0. Incoming bytes are lost and each one pulses `drop`.
  - `out_data = buf[rd_idx]`, `out_valid`=1, `out_last = (rd_idx == len-1)`.
  - On `out_valid & out_ready`, `rd_idx` increments.
  - On the last handshake: `sent_cnt` increments, `len` and `rd_idx` clear, and the state returns to HUNT.
- Error pulses and `drop` are mutually exclusive within a cycle.

## Timing
- The state register updates on the `clk` rising edge. Reset acts immediately on the `rst` falling edge, independent of `clk`.
- `out_valid` rises in the cycle after the LF byte is accepted.
- `out_data` and `out_last` are stable while `out_valid` is high and `out_ready` is low.
- Back-to-back bytes: one byte is output per cycle when `out_ready` is held high. A sentence of N bytes leaves EMIT N cycles after `out_valid` rises.
- `in_ready` returns high in the cycle after the last output handshake.
- Error pulses, `drop` and `sent_cnt` changes are registered and appear one cycle after the causing byte or handshake.
- Reset mid-sentence or mid-EMIT abandons the sentence. No partial tail is emitted after reset.

## Structure
- Package `gps_pkg`:
  - character constants `CH_DOLLAR`, `CH_STAR`, `CH_CR`, `CH_LF`;
  - state enum `nmea_st_t` {HUNT, BODY, CS_HI, CS_LO, CR, LF, EMIT};
  - hex-to-nibble function returning {valid, nibble}.
- Sub-module `nmea_line_ram`: `MAX_LEN`×8 storage, with a synchronous write port and an asynchronous read port indexed by `rd_idx`.
- Index width is `$clog2(MAX_LEN+1)`.

## Test plan
- Send `$A*41\r\n`. Required: 7 output bytes identical to the input, `out_last` on 0x0A, `sent_cnt`=1, no error pulses.
- Send `$AB*03\r\n`, then `$A*40\r\n`. Required: the first sentence is forwarded; the second produces one `crc_err` pulse, no output, and `sent_cnt` stays 1.
- Send `xx$X$A*41\r\n`. Required: only `$A*41\r\n` is emitted; the leading garbage and the `$X` fragment are discarded.
- Send `$A*4g\r\n`, and separately `$A*41\n`. Required: one `fmt_err` pulse each and no output.
- With `MAX_LEN`=82, send `$` followed by 82×`A`. Required: `ovf_err` pulses on the 83rd byte. A following `$A*41\r\n` is forwarded correctly.
- Apply `out_ready` toggling 1/0 during EMIT and inject 3 input bytes. Required: the output order is preserved, there are 3 `drop` pulses, and `in_ready` is low throughout EMIT.
- Assert `rst` low mid-EMIT. Required: all outputs return to their reset values and the state is HUNT.
